// File: rtl/div_pkg.sv
// Shared definitions for the RV32M iterative divider: op encodings, FSM states
// and small op-decoding helpers.
package div_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ABS  = 2'b01,
        CALC = 2'b10,
        FIX  = 2'b11
    } state_t;

    // funct3[0] clear means a signed operation (DIV/REM).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // funct3[1] set selects the remainder (REM/REMU).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/twos_neg.sv
// Combinational two's-complement negation; wraps modulo 2^N.
module twos_neg #(
    parameter int N = 32
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout
);

    assign dout = ~din + 1'b1;

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU: sign-magnitude conversion around a restoring
// divider that retires one quotient bit per clock; fixed 34-clock latency.
module div_unit
    import div_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             div0_q, div0_d;
    logic [N-1:0]     result_q, result_d;
    logic             done_q, done_d;

    logic [N-1:0]     q_neg, b_neg, r_neg;
    logic [N:0]       r_shift, r_sub;
    logic             op_signed;

    // q_q holds the raw dividend, then its magnitude, then the quotient, so one
    // negator serves both the operand magnitude and the quotient sign fix.
    twos_neg #(.N(N)) u_neg_q (.din(q_q), .dout(q_neg));
    twos_neg #(.N(N)) u_neg_b (.din(b_q), .dout(b_neg));
    twos_neg #(.N(N)) u_neg_r (.din(r_q), .dout(r_neg));

    // One extra bit on the shifted remainder keeps divisors above 2^(N-1) exact.
    assign r_shift   = {r_q, q_q[N-1]};
    assign r_sub     = r_shift - {1'b0, b_q};
    assign op_signed = op_is_signed(op_q);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        q_d      = q_q;
        b_d      = b_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        div0_d   = div0_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    q_d     = dividend;
                    b_d     = divisor;
                    state_d = ABS;
                end
            end
            ABS: begin
                if (op_signed && q_q[N-1]) q_d = q_neg;
                if (op_signed && b_q[N-1]) b_d = b_neg;
                qsign_d = op_signed && (q_q[N-1] ^ b_q[N-1]);
                rsign_d = op_signed && q_q[N-1];
                div0_d  = (b_q == '0);
                r_d     = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                if (!r_sub[N]) begin
                    r_d = r_sub[N-1:0];
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    r_d = r_shift[N-1:0];
                    q_d = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
            end
            FIX: begin
                // A zero divisor must leave the all-ones quotient un-negated.
                if (op_is_rem(op_q))
                    result_d = rsign_q ? r_neg : r_q;
                else
                    result_d = (qsign_q && !div0_q) ? q_neg : q_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            q_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            q_q      <= q_d;
            b_q      <= b_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            div0_q   <= div0_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
